tv_in_fetch: RTL

TV_IN_FETCH -- requirements
Module: tv_in_fetch

---
 rtl/tasks_parameters_pkg.sv | 6 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/tv_in_fetch.sv | 115 +++++++++++
 3 files changed

// File: rtl/tasks_parameters_pkg.sv
// tasks_parameters: fetch FSM states and AXI response codes shared by the
// test-vector fetch logic and its bench.
package tasks_parameters;
    typedef enum logic [1:0] {IDLE, AR, R, UNPACK} fetch_state_e;
    localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with fall-through read data and an occupancy
// count; pointers wrap modulo DEPTH (power of 2, >= 2).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok, rd_ok;

    always_comb begin
        rd_ok    = rd_en && count_q != '0;
        // a pop in the same cycle frees the slot, so a write at full is still legal
        wr_ok    = wr_en && (count_q != CW'(DEPTH) || rd_ok);
        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(rd_ok);
        count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
endmodule

// File: rtl/tv_in_fetch.sv
// tv_in_fetch: turns queued word addresses into single AXI4-Lite reads and
// streams each returned word into a byte FIFO, least significant byte first.
module tv_in_fetch import tasks_parameters::*; #(
    parameter int M_AXI_ADDR_WIDTH = 32,
    parameter int M_AXI_DATA_WIDTH = 32,
    parameter int REQ_FIFO_DEPTH   = 16,
    parameter int BYTE_FIFO_DEPTH  = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [M_AXI_ADDR_WIDTH-1:0] TV_REQ_ADDR,
    input  logic                        TV_REQ_WR_EN,
    output logic                        TV_REQ_READY,
    output logic [7:0]                  TV_IN_DATA,
    input  logic                        TV_IN_FIFO_RD_EN,
    output logic                        TV_IN_FIFO_NOT_EMPTY,
    output logic [M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                        M_AXI_ARVALID,
    output logic [2:0]                  M_AXI_ARPROT,
    input  logic                        M_AXI_ARREADY,
    input  logic [M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY,
    output logic                        rresp_err
);
    localparam int RCW = $clog2(REQ_FIFO_DEPTH) + 1;
    localparam int BCW = $clog2(BYTE_FIFO_DEPTH) + 1;

    fetch_state_e                state_q, state_d;
    logic [M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d, req_head;
    logic [M_AXI_DATA_WIDTH-1:0] word_q, word_d;
    logic [1:0]                  idx_q, idx_d;
    logic                        err_q, err_d;
    logic [RCW-1:0]              req_count;
    logic [BCW-1:0]              byte_count;
    logic                        req_pop, byte_wr;
    logic [7:0]                  byte_data;

    sync_fifo #(.WIDTH(M_AXI_ADDR_WIDTH), .DEPTH(REQ_FIFO_DEPTH)) u_req (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .wr_en  (TV_REQ_WR_EN),
        .wr_data(TV_REQ_ADDR),
        .rd_en  (req_pop),
        .rd_data(req_head),
        .count  (req_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(BYTE_FIFO_DEPTH)) u_byte (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .wr_en  (byte_wr),
        .wr_data(byte_data),
        .rd_en  (TV_IN_FIFO_RD_EN),
        .rd_data(TV_IN_DATA),
        .count  (byte_count)
    );

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        word_d   = word_q;
        idx_d    = idx_q;
        err_d    = err_q;
        req_pop  = 1'b0;
        byte_wr  = 1'b0;
        case (state_q)
            // only start a read when the whole word is guaranteed to fit
            IDLE: if (req_count != '0 && byte_count <= BCW'(BYTE_FIFO_DEPTH - 4)) begin
                req_pop  = 1'b1;
                araddr_d = req_head & ~M_AXI_ADDR_WIDTH'(3);
                state_d  = AR;
            end
            AR: if (M_AXI_ARREADY) state_d = R;
            R: if (M_AXI_RVALID) begin
                word_d  = M_AXI_RDATA;
                err_d   = err_q | (M_AXI_RRESP != RESP_OKAY);
                idx_d   = 2'd0;
                state_d = UNPACK;
            end
            UNPACK: begin
                byte_wr = 1'b1;
                idx_d   = idx_q + 2'd1;
                state_d = idx_q == 2'd3 ? IDLE : UNPACK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            araddr_q <= '0;
            word_q   <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    assign byte_data            = 8'(word_q >> {idx_q, 3'b000});
    assign TV_REQ_READY         = !i_rst && req_count != RCW'(REQ_FIFO_DEPTH);
    assign TV_IN_FIFO_NOT_EMPTY = byte_count != '0;
    assign M_AXI_ARADDR         = araddr_q;
    assign M_AXI_ARVALID        = state_q == AR;
    assign M_AXI_ARPROT         = 3'b000;
    assign M_AXI_RREADY         = state_q == R;
    assign rresp_err            = err_q;
endmodule
